// File: rtl/product_accumulator.sv
// product_accumulator
//   Consumes 128-bit products from the multiplier stage over its Done_Flag/ack
//   four-phase handshake and adds COUNT consecutive products into a widened
//   sum. The finished sum is offered on a valid/ack port. While that sum is
//   waiting to be consumed, ack is held low, which stalls the multiplier chain.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; takes priority over every other input
//   producto   product from the multiplier, sampled on the capture edge only
//   Done_Flag  multiplier result ready; held high until ack is seen
//   ack        acknowledge to the multiplier
//   sum        accumulated sum, PWIDTH+ACC_EXTRA bits, wraps modulo 2^width
//   sum_valid  sum complete and stable
//   sum_ack    downstream has consumed sum; only honoured while holding
//   overflow   sticky carry-out of the accumulator for the current sum
//   count      number of products accumulated into the current sum
module product_accumulator #(
  parameter int PWIDTH    = 128,
  parameter int ACC_EXTRA = 4,
  parameter int COUNT     = 4,
  parameter int CNTW      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PWIDTH-1:0]           producto,
  input  logic                        Done_Flag,
  output logic                        ack,
  output logic [PWIDTH+ACC_EXTRA-1:0] sum,
  output logic                        sum_valid,
  input  logic                        sum_ack,
  output logic                        overflow,
  output logic [CNTW-1:0]             count
);

  localparam int             SW      = PWIDTH + ACC_EXTRA;
  localparam logic [CNTW-1:0] COUNT_C = CNTW'(COUNT);

  // IDLE: waiting for a product. ACK_WAIT: product taken, waiting for the
  // multiplier to drop Done_Flag. HOLD: finished sum waiting for sum_ack.
  typedef enum logic [1:0] {IDLE, ACK_WAIT, HOLD} state_t;

  state_t          state, state_n;
  logic            ack_n, sum_valid_n, overflow_n;
  logic [SW-1:0]   sum_n;
  logic [CNTW-1:0] count_n;

  // One bit wider than the accumulator so the top bit is the carry-out.
  logic [SW:0]     add_res;
  assign add_res = {1'b0, sum} + {{(ACC_EXTRA+1){1'b0}}, producto};

  always_comb begin
    state_n     = state;
    ack_n       = ack;
    sum_n       = sum;
    sum_valid_n = sum_valid;
    overflow_n  = overflow;
    count_n     = count;
    case (state)
      IDLE: begin
        if (Done_Flag) begin
          sum_n      = add_res[SW-1:0];
          overflow_n = overflow | add_res[SW];
          count_n    = count + CNTW'(1);
          ack_n      = 1'b1;
          state_n    = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        // A level-high Done_Flag is one product; nothing happens until it drops.
        if (!Done_Flag) begin
          ack_n = 1'b0;
          if (count == COUNT_C) begin
            sum_valid_n = 1'b1;
            state_n     = HOLD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      HOLD: begin
        // ack stays low here, so a pending Done_Flag waits for the next IDLE edge.
        if (sum_ack) begin
          sum_valid_n = 1'b0;
          sum_n       = '0;
          count_n     = '0;
          overflow_n  = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ack       <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_n;
      ack       <= ack_n;
      sum       <= sum_n;
      sum_valid <= sum_valid_n;
      overflow  <= overflow_n;
      count     <= count_n;
    end
  end

endmodule
